cadence_meas: RTL and testbench

- Sits directly downstream of the cadence filter stage. Consumes the synchronized, debounced cadence_rise pulse.
- Measures the pedal-crank period in prescaled ticks.
- Publishes cadence_per (8-bit, saturating) plus a one-cycle per_vld strobe.
- Flags not_pedaling when no crank edge arrives within the timeout. The downstream assist/torque logic scales motor demand from these outputs.

---
 rtl/cadence_pkg.sv | 23 ++
 rtl/cadence_prescale.sv | 38 +++
 rtl/cadence_meas.sv | 118 +++++++++++
 tb/tb_cadence_meas.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cadence_pkg.sv
// cadence_pkg
//   Shared types and constants for the cadence measurement path.
//   - cad_state_t : measurement FSM states
//   - CAD_PER_MAX : saturated / "stopped" period value
//   - PSH_FAST / PSH_SLOW : prescaler tick exponents (tick every 2^PSH clk)
package cadence_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } cad_state_t;

  localparam logic [7:0] CAD_PER_MAX = 8'hFF;
  localparam int         PSH_FAST    = 8;
  localparam int         PSH_SLOW    = 16;

  // Tick exponent for a given speed selection.
  function automatic int psh_for(input logic fast_sim);
    return fast_sim ? PSH_FAST : PSH_SLOW;
  endfunction

endpackage

// File: rtl/cadence_prescale.sv
// cadence_prescale
//   16-bit free-running prescaler with synchronous clear. tick is high for
//   the one cycle in which the low PSH bits of the counter are all ones.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (counter -> 0)
//   clr  : synchronous clear (counter -> 0 on the next edge)
//   tick : prescaled tick, decoded from the current counter value
module cadence_prescale #(
  parameter int PSH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr) begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = &cnt_q[PSH-1:0];

endmodule

// File: rtl/cadence_meas.sv
// cadence_meas
//   Measures the crank period between accepted cadence rises in prescaled
//   ticks and publishes it with a one-cycle strobe. Flags not_pedaling while
//   no periodic cadence is present (before two accepted edges, or after a
//   full saturated tick count passes without an edge).
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   cadence_rise : one-clk pulse per filtered cadence rising edge
//   cadence_per  : last measured period in ticks, 8'hFF = stopped/unknown
//   per_vld      : one-clk strobe when cadence_per takes a new measurement
//   not_pedaling : high while no valid periodic cadence is present
module cadence_meas
  import cadence_pkg::*;
#(
  parameter logic       FAST_SIM = 1'b1,
  parameter logic [7:0] MIN_PER  = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cadence_rise,
  output logic [7:0] cadence_per,
  output logic       per_vld,
  output logic       not_pedaling
);

  localparam int PSH = psh_for(FAST_SIM);

  cad_state_t state_q, state_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic [7:0] per_q, per_d;
  logic       vld_q, vld_d;
  logic       np_q, np_d;

  logic tick;
  logic rise_ok;
  logic timeout;
  logic pre_clr;

  // Prescaler is held at zero in IDLE so the first measured period starts
  // cleanly from the accepted edge; it also restarts on every accepted edge.
  assign pre_clr = (state_q == IDLE) || rise_ok;

  cadence_prescale #(
    .PSH (PSH)
  ) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .tick (tick)
  );

  // In IDLE any edge starts a measurement; otherwise edges closer than
  // MIN_PER ticks are treated as glitches and leave the counters running.
  assign rise_ok = cadence_rise && ((state_q == IDLE) || (tick_cnt_q >= MIN_PER));
  assign timeout = (state_q != IDLE) && (tick_cnt_q == CAD_PER_MAX) && tick;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    per_d      = per_q;
    vld_d      = 1'b0;
    np_d       = np_q;

    if (tick && (tick_cnt_q != CAD_PER_MAX)) begin
      tick_cnt_d = tick_cnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = 8'd0;
        np_d       = 1'b1;
        if (rise_ok) begin
          state_d = ARM;
        end
      end
      ARM, RUN: begin
        // Checked before timeout so a coincident edge wins and captures the
        // pre-clear count (8'hFF in the coincident-timeout case).
        if (rise_ok) begin
          state_d    = RUN;
          per_d      = tick_cnt_q;
          vld_d      = 1'b1;
          np_d       = 1'b0;
          tick_cnt_d = 8'd0;
        end else if (timeout) begin
          state_d = IDLE;
          per_d   = CAD_PER_MAX;
          np_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= 8'd0;
      per_q      <= CAD_PER_MAX;
      vld_q      <= 1'b0;
      np_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      per_q      <= per_d;
      vld_q      <= vld_d;
      np_q       <= np_d;
    end
  end

  assign cadence_per  = per_q;
  assign per_vld      = vld_q;
  assign not_pedaling = np_q;

endmodule

// File: tb/tb_cadence_meas.sv
// tb_cadence_meas
//   Randomized + directed stimulus against a time-based reference model.
//   The model reasons in edge indices: ticks fall every 256 edges after the
//   last accepted rise, a rise coincident with a tick does not count it, and
//   a running measurement times out 65536 edges after the last accepted rise.
module tb_cadence_meas;

  logic       clk;
  logic       rst;
  logic       cadence_rise;
  logic [7:0] cadence_per;
  logic       per_vld;
  logic       not_pedaling;

  cadence_meas #(
    .FAST_SIM (1'b1),
    .MIN_PER  (8'd2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cadence_rise (cadence_rise),
    .cadence_per  (cadence_per),
    .per_vld      (per_vld),
    .not_pedaling (not_pedaling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    longint     t;
    logic [7:0] per;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state: 0 idle, 1 armed (one edge seen), 2 running.
  int         m_state = 0;
  longint     m_last  = 0;
  logic [7:0] m_per   = 8'hFF;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  // Apply any timeout that has elapsed by edge 'now'.
  task automatic model_advance(input longint now);
    if (m_state != 0 && (now - m_last) >= 64'd65536) begin
      m_state = 0;
      m_per   = 8'hFF;
    end
  endtask

  // Rise sampled at edge t.
  task automatic model_rise(input longint t);
    longint dt;
    longint n;
    exp_t   e;
    model_advance(t - 1);
    if (m_state == 0) begin
      m_state = 1;
      m_last  = t;
    end else begin
      dt = t - m_last;
      n  = (dt - 1) / 256;
      if (n > 255) n = 255;
      if (n >= 2) begin
        e.t   = t;
        e.per = n[7:0];
        sb_q.push_back(e);
        m_per   = n[7:0];
        m_state = 2;
        m_last  = t;
      end
    end
  endtask

  task automatic check_status(input string tag);
    logic [7:0] exp_per;
    model_advance(edge_n);
    exp_per = (m_state == 2) ? m_per : 8'hFF;
    check({tag, " cadence_per"}, cadence_per, exp_per);
    check({tag, " not_pedaling"}, not_pedaling, (m_state == 2) ? 0 : 1);
  endtask

  // Issue a rise sampled 'gap' edges after the current edge.
  task automatic do_gap(input int gap, input string tag);
    longint t;
    if (gap > 1) repeat (gap - 1) @(posedge clk);
    @(negedge clk);
    check_status({tag, " pre"});
    cadence_rise = 1'b1;
    @(posedge clk);
    #1;
    cadence_rise = 1'b0;
    t = edge_n;
    $display("rise %-10s edge=%0d gap=%0d", tag, t, gap);
    model_rise(t);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = 0;
    m_per   = 8'hFF;
    @(negedge clk);
    check_status(tag);
    check({tag, " per_vld"}, per_vld, 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation, at
  // the expected edge, with not_pedaling already low.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].t < edge_n) begin
      check("missing per_vld", 0, 1);
      void'(sb_q.pop_front());
    end
    if (per_vld) begin
      if (sb_q.size() == 0) begin
        check("unexpected per_vld", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("strobe edge=%0d cadence_per=%0d expected=%0d", edge_n, cadence_per, e.per);
        check("per_vld edge", edge_n, e.t);
        check("per value", cadence_per, e.per);
        check("np at strobe", not_pedaling, 0);
      end
    end
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    cadence_rise = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_status("reset");
    check("reset per_vld", per_vld, 0);
    repeat (300) @(posedge clk);
    @(negedge clk);
    check_status("idle");

    // Steady cadence, glitch rejection, rise coincident with tick 8.
    do_gap(5,    "first");
    do_gap(2600, "p10a");
    do_gap(300,  "glitch");
    do_gap(2300, "p10b");
    do_gap(2048, "tick7");
    do_gap(2600, "p10c");

    // Reset mid-RUN discards the measurement.
    do_reset("midrst");
    do_gap(50,   "rst_r1");
    do_gap(2600, "rst_r2");

    // Random gaps, including sub-MIN_PER glitches.
    for (int i = 0; i < 6; i++) begin
      do_gap($urandom_range(100, 1500), "rand");
    end

    // Ensure RUN, then let it time out.
    do_gap(2600, "pre_to");
    if (m_state != 2) do_gap(2600, "pre_to2");
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check_status("timeout");
    do_gap(10,   "post_to");
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_status("end");
    check("scoreboard empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
